// File: rtl/pistorm_bus_pkg.sv
// Shared definitions for the 68000 bus responder: FSM encoding, RnW polarity, synchronizer depth.
package pistorm_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_IGNORE  = 3'd1,
        ST_WAIT_DS = 3'd2,
        ST_ACCESS  = 3'd3,
        ST_SETUP   = 3'd4,
        ST_ACK     = 3'd5,
        ST_BERR    = 3'd6,
        ST_RELEASE = 3'd7
    } bus_state_t;

    localparam logic BUS_READ    = 1'b1;
    localparam logic BUS_WRITE   = 1'b0;
    localparam int   SYNC_STAGES = 2;

endpackage

// File: rtl/bus_input_sync.sv
// Purpose: N-bit multi-flop synchronizer for asynchronous bus strobes.
// Latency: STAGES sys_clk cycles.
// Backpressure: none, free-running sampler.
module bus_input_sync #(
    parameter int               WIDTH   = 1,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    (* async_reg = "true" *) logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/m68k_bus_target.sv
// Purpose: 68000 bus responder mapping a window onto a single-port backend, answering with nDTACK/nBERR.
// Latency: strobe sync (2) + decode + backend latency (+DATA_SETUP on reads) to nDTACK.
// Backpressure: mem_req held until mem_ack; nBERR after TIMEOUT cycles without ack.
module m68k_bus_target
    import pistorm_bus_pkg::*;
#(
    parameter logic [23:0] BASE_ADDR  = 24'hE90000,
    parameter int          WIN_BITS   = 16,
    parameter int          DATA_SETUP = 2,
    parameter int          TIMEOUT    = 1023
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                nAS,
    input  logic                nUDS,
    input  logic                nLDS,
    input  logic                RnW,
    input  logic [23:1]         A_IN,
    input  logic [15:0]         D_IN,
    output logic [15:0]         D_OUT,
    output logic                D_OE,
    output logic                nDTACK_OE,
    output logic                nBERR_OE,
    output logic                mem_req,
    output logic                mem_we,
    output logic [WIN_BITS-2:0] mem_addr,
    output logic [1:0]          mem_be,
    output logic [15:0]         mem_wdata,
    input  logic                mem_ack,
    input  logic [15:0]         mem_rdata
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    bus_state_t         state_q, state_d;
    logic [3:0]         strb_s;
    logic               nas_s, nuds_s, nlds_s, rnw_s;
    logic               win_hit;
    logic               rnw_q;
    logic [TMR_W-1:0]   tmr_q;
    logic [WIN_BITS-2:0] addr_q;
    logic [1:0]         be_q;
    logic [15:0]        wdata_q;
    logic [15:0]        rdata_q;

    // Strobes idle high after reset so a reset mid-cycle never fakes an AS fall.
    bus_input_sync #(
        .WIDTH   (4),
        .STAGES  (SYNC_STAGES),
        .RST_VAL (4'b1111)
    ) u_strb_sync (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .d       ({nAS, nUDS, nLDS, RnW}),
        .q       (strb_s)
    );

    assign nas_s  = strb_s[3];
    assign nuds_s = strb_s[2];
    assign nlds_s = strb_s[1];
    assign rnw_s  = strb_s[0];

    assign win_hit = (A_IN[23:WIN_BITS] == BASE_ADDR[23:WIN_BITS]);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        D_OE      = 1'b0;
        nDTACK_OE = 1'b0;
        nBERR_OE  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Level test: an AS fall seen during RELEASE is picked up here.
                if (!nas_s) state_d = win_hit ? ST_WAIT_DS : ST_IGNORE;
            end
            ST_IGNORE: begin
                if (nas_s) state_d = ST_IDLE;
            end
            ST_WAIT_DS: begin
                if (nas_s)                    state_d = ST_IDLE;
                else if (!nuds_s || !nlds_s)  state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                mem_req = 1'b1;
                if (mem_ack)                             state_d = (rnw_q == BUS_READ) ? ST_SETUP : ST_ACK;
                else if (tmr_q == TMR_W'(TIMEOUT - 1))   state_d = ST_BERR;
            end
            ST_SETUP: begin
                D_OE = 1'b1;
                if (tmr_q == TMR_W'(DATA_SETUP - 1)) state_d = ST_ACK;
            end
            ST_ACK: begin
                nDTACK_OE = 1'b1;
                D_OE      = (rnw_q == BUS_READ);
                if (nas_s) state_d = ST_RELEASE;
            end
            ST_BERR: begin
                nBERR_OE = 1'b1;
                if (nas_s) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Timer restarts on every state change, so it serves both the ACCESS timeout and SETUP hold.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tmr_q   <= '0;
            addr_q  <= '0;
            rnw_q   <= BUS_READ;
            be_q    <= 2'b00;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
        end else begin
            tmr_q <= (state_d != state_q) ? '0 : tmr_q + TMR_W'(1);
            if (state_q == ST_IDLE && !nas_s) begin
                addr_q <= A_IN[WIN_BITS-1:1];
                rnw_q  <= rnw_s;
            end
            if (state_q == ST_WAIT_DS && !nas_s && (!nuds_s || !nlds_s)) begin
                be_q    <= {~nuds_s, ~nlds_s};
                wdata_q <= D_IN;
            end
            if (state_q == ST_ACCESS && mem_ack && rnw_q == BUS_READ) begin
                rdata_q <= mem_rdata;
            end
        end
    end

    assign mem_we    = mem_req && (rnw_q == BUS_WRITE);
    assign mem_addr  = addr_q;
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign D_OUT     = rdata_q;

endmodule
